// File: rtl/picomem_arbiter_2m.sv
// picomem_arbiter_2m
//   Shares one PicoMem valid/ready slave between two masters.
//   Arbitration is round-robin. A grant is held until the slave completes the transfer.
//   A watchdog ends hung transfers with an error response.
//
// Handshake: a master raises mX_valid_i and holds it and its payload steady
//   until it sees a single-cycle mX_ready_o. The slave completes the forwarded
//   transfer by asserting s_ready_i; s_rdata_i is only looked at in that cycle.
//   Completion is passed through combinationally to the granted master.
//
// Ports
//   clk, resetn             clock (rising edge), synchronous active-low reset
//   mX_valid_i/addr_i/      master X request, byte address, write data,
//   wdata_i/wstrb_i         byte strobes (0 = read)
//   mX_ready_o/rdata_o      master X completion pulse and read data
//   s_valid_o/addr_o/       request forwarded to the slave (muxed from owner;
//   wdata_o/wstrb_o         payload is zero while idle)
//   s_ready_i/rdata_i       slave completion and read data
//   grant_o                 one-hot owner, 2'b00 when idle
//   timeout_err_o           1-cycle pulse when the watchdog aborts a transfer
//   state_o                 raw FSM state for debug/checkers
module picomem_arbiter_2m #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_wstrb_i,
  output logic        m0_ready_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_valid_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_wstrb_i,
  output logic        m1_ready_o,
  output logic [31:0] m1_rdata_o,
  output logic        s_valid_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_wstrb_o,
  input  logic        s_ready_i,
  input  logic [31:0] s_rdata_i,
  output logic [1:0]  grant_o,
  output logic        timeout_err_o,
  output logic [1:0]  state_o
);

  // State encodings double as the one-hot grant value.
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] BUSY0 = 2'b01;
  localparam logic [1:0] BUSY1 = 2'b10;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic WD_EN = (TIMEOUT_CYCLES != 0);

  logic [1:0]       state_q, state_d;
  logic             rr_pri_q, rr_pri_d;   // 0: master 0 preferred on a tie
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             busy0, busy1, busy;
  logic             act_valid;
  logic             done, tmo, abort;
  logic [31:0]      resp_data;

  always_comb begin
    busy0     = (state_q == BUSY0);
    busy1     = (state_q == BUSY1);
    busy      = busy0 | busy1;
    act_valid = (busy0 & m0_valid_i) | (busy1 & m1_valid_i);

    // A master dropping valid is a protocol abort and outranks any slave
    // response or timeout in that cycle. s_ready beats the timeout.
    abort = busy & ~act_valid;
    done  = act_valid & s_ready_i;
    tmo   = act_valid & ~s_ready_i & WD_EN & (cnt_q == CNT_LAST);

    resp_data = 32'h0;
    if (done)     resp_data = s_rdata_i;
    else if (tmo) resp_data = ERR_RDATA;

    // Slave-side mux; zero payload while idle.
    s_valid_o = act_valid;
    s_addr_o  = 32'h0;
    s_wdata_o = 32'h0;
    s_wstrb_o = 4'h0;
    if (busy0) begin
      s_addr_o  = m0_addr_i;
      s_wdata_o = m0_wdata_i;
      s_wstrb_o = m0_wstrb_i;
    end else if (busy1) begin
      s_addr_o  = m1_addr_i;
      s_wdata_o = m1_wdata_i;
      s_wstrb_o = m1_wstrb_i;
    end

    m0_ready_o    = busy0 & (done | tmo);
    m0_rdata_o    = busy0 ? resp_data : 32'h0;
    m1_ready_o    = busy1 & (done | tmo);
    m1_rdata_o    = busy1 ? resp_data : 32'h0;
    timeout_err_o = tmo;
    grant_o       = state_q;
    state_o       = state_q;

    state_d  = state_q;
    rr_pri_d = rr_pri_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_valid_i && m1_valid_i) state_d = rr_pri_q ? BUSY1 : BUSY0;
        else if (m0_valid_i)          state_d = BUSY0;
        else if (m1_valid_i)          state_d = BUSY1;
      end
      BUSY0, BUSY1: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (done || tmo) begin
          state_d  = IDLE;
          cnt_d    = '0;
          // Hand priority to the master that did not just finish.
          rr_pri_d = busy0;
        end else if (WD_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      rr_pri_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_pri_q <= rr_pri_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_picomem_arbiter_2m.sv
module tb_picomem_arbiter_2m;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  grant, state;
  logic        timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  picomem_arbiter_2m #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEADBEEF)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid_i(m0_valid), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_wstrb_i(m0_wstrb),
    .m0_ready_o(m0_ready), .m0_rdata_o(m0_rdata),
    .m1_valid_i(m1_valid), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_wstrb_i(m1_wstrb),
    .m1_ready_o(m1_ready), .m1_rdata_o(m1_rdata),
    .s_valid_o(s_valid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
    .s_ready_i(s_ready), .s_rdata_i(s_rdata),
    .grant_o(grant), .timeout_err_o(timeout_err), .state_o(state)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        m0v; logic [31:0] m0a; logic [31:0] m0d; logic [3:0] m0s;
    logic        m1v; logic [31:0] m1a; logic [31:0] m1d; logic [3:0] m1s;
    logic        sr;  logic [31:0] srd;
    logic [1:0]  eg;  logic        esv;
    logic        em0r; logic [31:0] em0d;
    logic        em1r; logic [31:0] em1d;
    logic        eto;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic rst_n,
                   input logic m0v, input logic [31:0] m0a, input logic [31:0] m0d, input logic [3:0] m0s,
                   input logic m1v, input logic [31:0] m1a, input logic [31:0] m1d, input logic [3:0] m1s,
                   input logic sr, input logic [31:0] srd,
                   input logic [1:0] eg, input logic esv,
                   input logic em0r, input logic [31:0] em0d,
                   input logic em1r, input logic [31:0] em1d, input logic eto);
    vec_t r;
    r.rst_n = rst_n;
    r.m0v = m0v; r.m0a = m0a; r.m0d = m0d; r.m0s = m0s;
    r.m1v = m1v; r.m1a = m1a; r.m1d = m1d; r.m1s = m1s;
    r.sr = sr; r.srd = srd; r.eg = eg; r.esv = esv;
    r.em0r = em0r; r.em0d = em0d; r.em1r = em1r; r.em1d = em1d; r.eto = eto;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic idle_inputs();
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready = 1'b0; s_rdata = '0;
  endtask

  // driver: apply one table row, then compare the combinational outputs
  task automatic run_vec(input int i, input vec_t r);
    logic [31:0] ea, ed;
    logic [3:0]  es;
    @(negedge clk);
    resetn = r.rst_n;
    m0_valid = r.m0v; m0_addr = r.m0a; m0_wdata = r.m0d; m0_wstrb = r.m0s;
    m1_valid = r.m1v; m1_addr = r.m1a; m1_wdata = r.m1d; m1_wstrb = r.m1s;
    s_ready = r.sr; s_rdata = r.srd;
    #1;
    // the slave payload must follow the owner named in the row
    ea = '0; ed = '0; es = '0;
    if (r.eg == 2'b01) begin ea = r.m0a; ed = r.m0d; es = r.m0s; end
    if (r.eg == 2'b10) begin ea = r.m1a; ed = r.m1d; es = r.m1s; end
    chk($sformatf("v%0d.grant", i),    32'(grant),       32'(r.eg));
    chk($sformatf("v%0d.state", i),    32'(state),       32'(r.eg));
    chk($sformatf("v%0d.s_valid", i),  32'(s_valid),     32'(r.esv));
    chk($sformatf("v%0d.s_addr", i),   s_addr,           ea);
    chk($sformatf("v%0d.s_wdata", i),  s_wdata,          ed);
    chk($sformatf("v%0d.s_wstrb", i),  32'(s_wstrb),     32'(es));
    chk($sformatf("v%0d.m0_ready", i), 32'(m0_ready),    32'(r.em0r));
    chk($sformatf("v%0d.m0_rdata", i), m0_rdata,         r.em0d);
    chk($sformatf("v%0d.m1_ready", i), 32'(m1_ready),    32'(r.em1r));
    chk($sformatf("v%0d.m1_rdata", i), m1_rdata,         r.em1d);
    chk($sformatf("v%0d.tmo", i),      32'(timeout_err), 32'(r.eto));
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);

    // reset state
    @(negedge clk); #1;
    chk("rst.grant", 32'(grant), 0);
    chk("rst.s_valid", 32'(s_valid), 0);
    chk("rst.s_addr", s_addr, 0);
    chk("rst.m_ready", 32'({m0_ready, m1_ready}), 0);
    chk("rst.m_rdata", m0_rdata | m1_rdata, 0);
    chk("rst.tmo", 32'(timeout_err), 0);

    //  rst m0v m0a         m0d            m0s   m1v m1a         m1d            m1s   sr srd            eg     esv m0r m0d           m1r m1d           to
    // m0 read, 1 wait state; stale s_ready in idle is ignored
    v(1, 1, 32'h10, 32'h0, 4'h0,  0, 32'h0,  32'h0, 4'h0,  0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 32'h0, 0);
    v(1, 1, 32'h10, 32'h0, 4'h0,  0, 32'h0,  32'h0, 4'h0,  0, 32'h0,        2'b01, 1, 0, 32'h0,        0, 32'h0, 0);
    v(1, 1, 32'h10, 32'h0, 4'h0,  0, 32'h0,  32'h0, 4'h0,  1, 32'h12345678, 2'b01, 1, 1, 32'h12345678, 0, 32'h0, 0);
    v(1, 0, 32'h0,  32'h0, 4'h0,  0, 32'h0,  32'h0, 4'h0,  1, 32'hFFFF0000, 2'b00, 0, 0, 32'h0,        0, 32'h0, 0);
    // reset, then simultaneous requests: m0 first, then m1
    v(0, 0, 32'h0,  32'h0, 4'h0,  0, 32'h0,  32'h0, 4'h0,  0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 32'h0, 0);
    v(1, 1, 32'h20, 32'h0, 4'h0,  1, 32'h30, 32'h0, 4'h0,  0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 32'h0, 0);
    v(1, 1, 32'h20, 32'h0, 4'h0,  1, 32'h30, 32'h0, 4'h0,  1, 32'hA1,       2'b01, 1, 1, 32'hA1,       0, 32'h0, 0);
    v(1, 0, 32'h0,  32'h0, 4'h0,  1, 32'h30, 32'h0, 4'h0,  0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 32'h0, 0);
    v(1, 0, 32'h0,  32'h0, 4'h0,  1, 32'h30, 32'h0, 4'h0,  1, 32'hB2,       2'b10, 1, 0, 32'h0,        1, 32'hB2, 0);
    v(1, 0, 32'h0,  32'h0, 4'h0,  0, 32'h0,  32'h0, 4'h0,  0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 32'h0, 0);
    // m0 requests continuously, m1 twice: grants alternate
    v(1, 1, 32'h40, 32'h0, 4'h0,  1, 32'h50, 32'h0, 4'h0,  0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 32'h0, 0);
    v(1, 1, 32'h40, 32'h0, 4'h0,  1, 32'h50, 32'h0, 4'h0,  1, 32'hC3,       2'b01, 1, 1, 32'hC3,       0, 32'h0, 0);
    v(1, 1, 32'h44, 32'h0, 4'h0,  1, 32'h50, 32'h0, 4'h0,  0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 32'h0, 0);
    v(1, 1, 32'h44, 32'h0, 4'h0,  1, 32'h50, 32'h0, 4'h0,  1, 32'hD4,       2'b10, 1, 0, 32'h0,        1, 32'hD4, 0);
    v(1, 1, 32'h44, 32'h0, 4'h0,  0, 32'h0,  32'h0, 4'h0,  0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 32'h0, 0);
    v(1, 1, 32'h44, 32'h0, 4'h0,  0, 32'h0,  32'h0, 4'h0,  1, 32'hE5,       2'b01, 1, 1, 32'hE5,       0, 32'h0, 0);
    v(1, 1, 32'h48, 32'h0, 4'h0,  1, 32'h54, 32'h0, 4'h0,  0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 32'h0, 0);
    v(1, 1, 32'h48, 32'h0, 4'h0,  1, 32'h54, 32'h0, 4'h0,  0, 32'h0,        2'b10, 1, 0, 32'h0,        0, 32'h0, 0);
    v(1, 1, 32'h48, 32'h0, 4'h0,  1, 32'h54, 32'h0, 4'h0,  1, 32'hF6,       2'b10, 1, 0, 32'h0,        1, 32'hF6, 0);
    v(1, 0, 32'h0,  32'h0, 4'h0,  0, 32'h0,  32'h0, 4'h0,  0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 32'h0, 0);
    // m1 byte-2 write, then read-back
    v(1, 0, 32'h0,  32'h0, 4'h0,  1, 32'h104, 32'hA5A5A5A5, 4'b0100, 0, 32'h0, 2'b00, 0, 0, 32'h0,     0, 32'h0, 0);
    v(1, 0, 32'h0,  32'h0, 4'h0,  1, 32'h104, 32'hA5A5A5A5, 4'b0100, 0, 32'h0, 2'b10, 1, 0, 32'h0,     0, 32'h0, 0);
    v(1, 0, 32'h0,  32'h0, 4'h0,  1, 32'h104, 32'hA5A5A5A5, 4'b0100, 1, 32'h0, 2'b10, 1, 0, 32'h0,     1, 32'h0, 0);
    v(1, 0, 32'h0,  32'h0, 4'h0,  0, 32'h0,  32'h0, 4'h0,  0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 32'h0, 0);
    v(1, 0, 32'h0,  32'h0, 4'h0,  1, 32'h104, 32'h0, 4'h0, 0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 32'h0, 0);
    v(1, 0, 32'h0,  32'h0, 4'h0,  1, 32'h104, 32'h0, 4'h0, 1, 32'h00A50000, 2'b10, 1, 0, 32'h0,        1, 32'h00A50000, 0);
    v(1, 0, 32'h0,  32'h0, 4'h0,  0, 32'h0,  32'h0, 4'h0,  0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 32'h0, 0);
    // m0 drops valid mid-transfer: no ready, priority unchanged (m0 wins next tie)
    v(1, 1, 32'h60, 32'h0, 4'h0,  0, 32'h0,  32'h0, 4'h0,  0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 32'h0, 0);
    v(1, 1, 32'h60, 32'h0, 4'h0,  0, 32'h0,  32'h0, 4'h0,  0, 32'h0,        2'b01, 1, 0, 32'h0,        0, 32'h0, 0);
    v(1, 0, 32'h60, 32'h0, 4'h0,  0, 32'h0,  32'h0, 4'h0,  1, 32'h77,       2'b01, 0, 0, 32'h0,        0, 32'h0, 0);
    v(1, 0, 32'h0,  32'h0, 4'h0,  0, 32'h0,  32'h0, 4'h0,  0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 32'h0, 0);
    v(1, 1, 32'h64, 32'h0, 4'h0,  1, 32'h68, 32'h0, 4'h0,  0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 32'h0, 0);
    v(1, 1, 32'h64, 32'h0, 4'h0,  1, 32'h68, 32'h0, 4'h0,  1, 32'h88,       2'b01, 1, 1, 32'h88,       0, 32'h0, 0);
    v(1, 0, 32'h0,  32'h0, 4'h0,  0, 32'h0,  32'h0, 4'h0,  0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 32'h0, 0);

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // watchdog: slave never ready, abort on the 8th BUSY cycle
    @(negedge clk);
    idle_inputs(); m0_valid = 1'b1; m0_addr = 32'h70;
    #1 chk("wd.idle.grant", 32'(grant), 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      chk($sformatf("wd%0d.grant", k), 32'(grant), 32'h1);
      chk($sformatf("wd%0d.m0_ready", k), 32'(m0_ready), (k == 8) ? 32'h1 : 32'h0);
      chk($sformatf("wd%0d.tmo", k), 32'(timeout_err), (k == 8) ? 32'h1 : 32'h0);
      chk($sformatf("wd%0d.m0_rdata", k), m0_rdata, (k == 8) ? 32'hDEADBEEF : 32'h0);
    end
    @(negedge clk);
    m0_valid = 1'b0;
    #1;
    chk("wd.after.grant", 32'(grant), 0);
    chk("wd.after.tmo", 32'(timeout_err), 0);

    // s_ready on the timeout cycle wins: normal data, no error
    @(negedge clk);
    m0_valid = 1'b1; m0_addr = 32'h74;
    #1 chk("wd2.idle.grant", 32'(grant), 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 8) begin s_ready = 1'b1; s_rdata = 32'h13579BDF; end
      #1;
      chk($sformatf("wd2_%0d.m0_ready", k), 32'(m0_ready), (k == 8) ? 32'h1 : 32'h0);
      chk($sformatf("wd2_%0d.tmo", k), 32'(timeout_err), 0);
      chk($sformatf("wd2_%0d.m0_rdata", k), m0_rdata, (k == 8) ? 32'h13579BDF : 32'h0);
    end
    @(negedge clk);
    idle_inputs();
    #1 chk("wd2.after.grant", 32'(grant), 0);

    // reset during BUSY1: drop to idle, no m1_ready, then m0 preferred
    @(negedge clk);
    m1_valid = 1'b1; m1_addr = 32'h80;
    #1 chk("rb.idle.grant", 32'(grant), 0);
    @(negedge clk); #1;
    chk("rb.busy1.grant", 32'(grant), 32'h2);
    chk("rb.busy1.s_valid", 32'(s_valid), 1);
    @(negedge clk);
    resetn = 1'b0;
    #1 chk("rb.pre.m1_ready", 32'(m1_ready), 0);
    @(negedge clk); #1;
    chk("rb.post.grant", 32'(grant), 0);
    chk("rb.post.s_valid", 32'(s_valid), 0);
    chk("rb.post.m1_ready", 32'(m1_ready), 0);
    @(negedge clk);
    resetn = 1'b1; m0_valid = 1'b1; m0_addr = 32'h90;
    #1 chk("rb.rel.grant", 32'(grant), 0);
    @(negedge clk);
    s_ready = 1'b1; s_rdata = 32'h0BADF00D;
    #1;
    chk("rb.m0first.grant", 32'(grant), 32'h1);
    chk("rb.m0first.m0_rdata", m0_rdata, 32'h0BADF00D);
    chk("rb.m0first.m1_ready", 32'(m1_ready), 0);
    @(negedge clk);
    idle_inputs();
    #1 chk("rb.end.grant", 32'(grant), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
